mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 164 ++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Request/response controller that sequences 16/32-bit loads and stores onto a 16-bit word memory.
// Build option: define MEM_SIGN_EXT_EN to sign-extend single-word loads (zero-extended otherwise).
module mem_access_ctrl #(
    parameter int unsigned MEM_DEPTH = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_double,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic        mem_read_enable,
    output logic [31:0] mem_read_addr,
    input  logic [15:0] mem_read_data,
    output logic        mem_write_enable,
    output logic [31:0] mem_write_addr,
    output logic [15:0] mem_write_data
);

    typedef enum logic [2:0] {IDLE, ACC0, ACC1, CAP, DONE} state_t;

    state_t      state_reg, state_next;
    logic [31:0] addr_reg, addr_next;
    logic [31:0] wdata_reg, wdata_next;
    logic        write_reg, write_next;
    logic        double_reg, double_next;
    logic        err_reg, err_next;
    logic [31:0] rdata_reg, rdata_next;
    logic        resp_valid_reg;
    logic        resp_err_reg;
    logic [31:0] resp_rdata_reg;

    logic        rd_en, wr_en;
    logic [31:0] rd_addr, wr_addr;
    logic [15:0] wr_data;
    logic        accept;
    logic        req_err;
    logic [32:0] addr_ext;
    logic [32:0] depth_ext;
    logic [31:0] ext_word;

    // 33-bit compare so that addr+1 at 0xFFFFFFFF cannot wrap into range
    assign addr_ext  = {1'b0, req_addr};
    assign depth_ext = 33'(MEM_DEPTH);
    assign req_err   = (addr_ext >= depth_ext) |
                       (req_double & ((addr_ext + 33'd1) >= depth_ext));

`ifdef MEM_SIGN_EXT_EN
    assign ext_word = {{16{mem_read_data[15]}}, mem_read_data};
`else
    assign ext_word = {16'h0000, mem_read_data};
`endif

    assign req_ready = (state_reg == IDLE) & ~rst;
    assign accept    = req_valid & req_ready;

    always_comb begin
        state_next  = state_reg;
        addr_next   = addr_reg;
        wdata_next  = wdata_reg;
        write_next  = write_reg;
        double_next = double_reg;
        err_next    = err_reg;
        rdata_next  = rdata_reg;
        rd_en       = 1'b0;
        wr_en       = 1'b0;
        rd_addr     = 32'h0;
        wr_addr     = 32'h0;
        wr_data     = 16'h0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    addr_next   = req_addr;
                    wdata_next  = req_wdata;
                    write_next  = req_write;
                    double_next = req_double;
                    err_next    = req_err;
                    state_next  = req_err ? DONE : ACC0;
                end
            end
            ACC0: begin
                if (write_reg) begin
                    wr_en   = 1'b1;
                    wr_addr = addr_reg;
                    wr_data = double_reg ? wdata_reg[31:16] : wdata_reg[15:0];
                end else begin
                    rd_en   = 1'b1;
                    rd_addr = addr_reg;
                end
                if (double_reg)     state_next = ACC1;
                else if (write_reg) state_next = DONE;
                else                state_next = CAP;
            end
            ACC1: begin
                if (write_reg) begin
                    wr_en   = 1'b1;
                    wr_addr = addr_reg + 32'd1;
                    wr_data = wdata_reg[15:0];
                end else begin
                    // data for addr (issued in ACC0) is valid now
                    rd_en             = 1'b1;
                    rd_addr           = addr_reg + 32'd1;
                    rdata_next[31:16] = mem_read_data;
                end
                state_next = write_reg ? DONE : CAP;
            end
            CAP: begin
                rdata_next = double_reg ? {rdata_reg[31:16], mem_read_data} : ext_word;
                state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            addr_reg       <= 32'h0;
            wdata_reg      <= 32'h0;
            write_reg      <= 1'b0;
            double_reg     <= 1'b0;
            err_reg        <= 1'b0;
            rdata_reg      <= 32'h0;
            resp_valid_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
            resp_rdata_reg <= 32'h0;
        end else begin
            state_reg      <= state_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
            write_reg      <= write_next;
            double_reg     <= double_next;
            err_reg        <= err_next;
            rdata_reg      <= rdata_next;
            // response is registered out of DONE, giving a one-cycle pulse
            resp_valid_reg <= (state_reg == DONE);
            resp_err_reg   <= (state_reg == DONE) & err_reg;
            if ((state_reg == DONE) && !write_reg && !err_reg)
                resp_rdata_reg <= rdata_reg;
        end
    end

    assign resp_valid = resp_valid_reg;
    assign resp_err   = resp_err_reg;
    assign resp_rdata = resp_rdata_reg;

    // reset kills any in-flight access combinationally
    assign mem_read_enable  = rd_en & ~rst;
    assign mem_read_addr    = mem_read_enable ? rd_addr : 32'h0;
    assign mem_write_enable = wr_en & ~rst;
    assign mem_write_addr   = mem_write_enable ? wr_addr : 32'h0;
    assign mem_write_data   = mem_write_enable ? wr_data : 16'h0;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl with a small 64-word memory model.
module tb_mem_access_ctrl;

    localparam int unsigned DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic        req_double = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        mem_read_enable;
    logic [31:0] mem_read_addr;
    logic [15:0] mem_read_data = 16'h0;
    logic        mem_write_enable;
    logic [31:0] mem_write_addr;
    logic [15:0] mem_write_data;

    logic [15:0] mem [0:DEPTH-1];
    int tests = 0;
    int fails = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int viol_cnt = 0;
    logic [31:0] exp_ext;

    mem_access_ctrl #(.MEM_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_double(req_double), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .mem_read_enable(mem_read_enable), .mem_read_addr(mem_read_addr),
        .mem_read_data(mem_read_data),
        .mem_write_enable(mem_write_enable), .mem_write_addr(mem_write_addr),
        .mem_write_data(mem_write_data)
    );

    always #5 clk = ~clk;

    // memory model: registered read, write on negedge
    always @(posedge clk)
        if (mem_read_enable) mem_read_data <= mem[mem_read_addr[5:0]];
    always @(negedge clk)
        if (mem_write_enable) mem[mem_write_addr[5:0]] <= mem_write_data;

    always @(negedge clk) begin
        if (mem_write_enable) wr_cnt++;
        if (mem_read_enable) rd_cnt++;
        if ((mem_write_enable && mem_read_enable) ||
            (!mem_write_enable && (mem_write_addr != 32'h0 || mem_write_data != 16'h0)) ||
            (!mem_read_enable && mem_read_addr != 32'h0))
            viol_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input string tag, input logic w, input logic d,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int exp_lat, input logic exp_err,
                          input logic [31:0] exp_rdata, input int exp_wr, input int exp_rd);
        int lat;
        int wr0;
        int rd0;
        @(negedge clk);
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
        req_write = w; req_double = d; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        wr0 = wr_cnt; rd0 = rd_cnt;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!resp_valid && lat < 20);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_err"}, 32'(resp_err), 32'(exp_err));
        check({tag, "_rdata"}, resp_rdata, exp_rdata);
        check({tag, "_writes"}, 32'(wr_cnt - wr0), 32'(exp_wr));
        check({tag, "_reads"}, 32'(rd_cnt - rd0), 32'(exp_rd));
        @(posedge clk); #1;
        check({tag, "_pulse_end"}, {30'h0, resp_valid, resp_err}, 32'h0);
    endtask

    initial begin
        int pulses;
        logic phase3;
`ifdef MEM_SIGN_EXT_EN
        exp_ext = 32'hFFFF8001;
`else
        exp_ext = 32'h00008001;
`endif
        for (int i = 0; i < DEPTH; i++) mem[i] = 16'h0;

        // reset state, with a request pending that must not be seen
        req_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_rdata", resp_rdata, 32'h0);
        check("rst_enables", {30'h0, mem_read_enable, mem_write_enable}, 32'h0);
        req_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("post_rst_ready", 32'(req_ready), 32'd1);

        do_req("st5",   1'b1, 1'b0, 32'd5,  32'h0000ABCD, 2, 1'b0, 32'h0, 1, 0);
        check("mem5", 32'(mem[5]), 32'h0000ABCD);
        do_req("dst10", 1'b1, 1'b1, 32'd10, 32'h12345678, 3, 1'b0, 32'h0, 2, 0);
        check("mem10", 32'(mem[10]), 32'h00001234);
        check("mem11", 32'(mem[11]), 32'h00005678);
        do_req("dld10", 1'b0, 1'b1, 32'd10, 32'h0, 4, 1'b0, 32'h12345678, 0, 2);
        do_req("st30",  1'b1, 1'b0, 32'd30, 32'hDEAD8001, 2, 1'b0, 32'h12345678, 1, 0);
        check("mem30", 32'(mem[30]), 32'h00008001);
        do_req("ld30",  1'b0, 1'b0, 32'd30, 32'h0, 3, 1'b0, exp_ext, 0, 1);
        do_req("ld10",  1'b0, 1'b0, 32'd10, 32'h0, 3, 1'b0, 32'h00001234, 0, 1);
        // out-of-range: second word of double past the end, and a huge address
        do_req("dld63_err", 1'b0, 1'b1, 32'd63, 32'h0, 1, 1'b1, 32'h00001234, 0, 0);
        do_req("stmax_err", 1'b1, 1'b0, 32'hFFFFFFFF, 32'h0000BEEF, 1, 1'b1, 32'h00001234, 0, 0);
        do_req("dst62", 1'b1, 1'b1, 32'd62, 32'hAAAA5555, 3, 1'b0, 32'h00001234, 2, 0);
        do_req("ld63",  1'b0, 1'b0, 32'd63, 32'h0, 3, 1'b0, 32'h00005555, 0, 1);

        // reset during ACC1 of a double store
        @(negedge clk);
        req_write = 1'b1; req_double = 1'b1; req_addr = 32'd20; req_wdata = 32'hCAFEBEEF;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("midrst_wen", 32'(mem_write_enable), 32'd0);
        check("midrst_waddr", mem_write_addr, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("midrst_ready", 32'(req_ready), 32'd1);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (resp_valid) pulses++;
        end
        check("midrst_pulses", 32'(pulses), 32'd0);
        check("midrst_mem20", 32'(mem[20]), 32'h0000CAFE);
        check("midrst_mem21", 32'(mem[21]), 32'h00000000);
        check("midrst_rdata", resp_rdata, 32'h0);

        // req_valid held high: accepted only in IDLE, every 4 cycles for a single load
        @(negedge clk);
        req_write = 1'b0; req_double = 1'b0; req_addr = 32'd10; req_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            phase3 = ((i % 4) == 3);
            check($sformatf("b2b_ready_%0d", i), 32'(req_ready), 32'(phase3));
            check($sformatf("b2b_resp_%0d", i), 32'(resp_valid), 32'(phase3));
            check($sformatf("b2b_ren_%0d", i), 32'(mem_read_enable), 32'((i % 4) == 0));
            check($sformatf("b2b_wen_%0d", i), 32'(mem_write_enable), 32'd0);
            if (i == 7) req_valid = 1'b0;
        end
        @(posedge clk); #1;
        check("b2b_idle", {30'h0, req_ready, resp_valid}, 32'h2);
        check("b2b_rdata", resp_rdata, 32'h00001234);

        @(negedge clk);
        check("mem_if_rules", 32'(viol_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
